sdes_iter_core: RTL

Parametrised, iterative Simplified-DES engine with valid/ready handshaking on both sides. It supports encrypt or decrypt per block, a configurable Feistel round count, and optional CBC chaining. S-box contents come from run-time table inputs. It is the next-generation datapath behind the existing S-DES top level and executes one Feistel round per clock.

---
 rtl/sdes_iter_core.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sdes_iter_core.sv
// ---------------------------------------------------------------------------
// sdes_iter_core
//
// Iterative Simplified-DES engine. One Feistel round is executed per clock.
// A block is accepted in IDLE, runs ROUNDS rounds in ROUND, then waits in
// DONE until the consumer takes the result. Encrypt/decrypt is chosen per
// block; CBC chaining is a build-time option.
//
// Parameters
//   ROUNDS  Feistel rounds per block (1..16); 2 gives standard S-DES
//   CBC_EN  1 = CBC chaining, 0 = ECB
//   IV      chain register value after reset / chain_clr
//
// Ports
//   clk        sole clock, rising edge
//   reset      synchronous, active-low
//   in_valid   block offered on data_in
//   in_ready   core can accept a block (IDLE only)
//   data_in    plaintext (encrypt) or ciphertext (decrypt)
//   key        10-bit key, sampled at acceptance
//   decrypt    0 = encrypt, 1 = decrypt, sampled at acceptance
//   S0, S1     S-box tables, entry idx=row*4+col at bits [2*idx+1:2*idx]
//   chain_clr  reload chain register with IV (IDLE only)
//   out_valid  data_out holds a result
//   out_ready  consumer takes data_out
//   data_out   registered result, stable while out_valid=1
// ---------------------------------------------------------------------------
module sdes_iter_core #(
    parameter int         ROUNDS = 2,
    parameter bit         CBC_EN = 1'b0,
    parameter logic [7:0] IV     = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  data_in,
    input  logic [9:0]  key,
    input  logic        decrypt,
    input  logic [31:0] S0,
    input  logic [31:0] S1,
    input  logic        chain_clr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  data_out
);

    localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Fixed permutations (bit 1 of each table = MSB)
    // -----------------------------------------------------------------------
    function automatic logic [9:0] p10(input logic [9:0] k);
        return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
    endfunction

    function automatic logic [7:0] p8(input logic [9:0] k);
        return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
    endfunction

    function automatic logic [7:0] ip(input logic [7:0] x);
        return {x[6], x[2], x[5], x[7], x[4], x[0], x[3], x[1]};
    endfunction

    function automatic logic [7:0] ip_inv(input logic [7:0] x);
        return {x[4], x[7], x[5], x[3], x[1], x[6], x[0], x[2]};
    endfunction

    function automatic logic [7:0] ep(input logic [3:0] r);
        return {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
    endfunction

    function automatic logic [3:0] p4(input logic [3:0] s);
        return {s[2], s[0], s[1], s[3]};
    endfunction

    // Row is the outer bit pair n1n4, column the inner pair n2n3.
    function automatic logic [1:0] sbox(input logic [31:0] tbl, input logic [3:0] n);
        logic [3:0] idx;
        idx = {n[3], n[0], n[2], n[1]};
        return tbl[{idx, 1'b0} +: 2];
    endfunction

    function automatic logic [4:0] rol5(input logic [4:0] v, input logic [2:0] s);
        logic [4:0] o;
        case (s)
            3'd1:    o = {v[3:0], v[4]};
            3'd2:    o = {v[2:0], v[4:3]};
            3'd3:    o = {v[1:0], v[4:2]};
            3'd4:    o = {v[0], v[4:1]};
            default: o = v;
        endcase
        return o;
    endfunction

    // Cumulative left-rotate for round r (1-based): 1, 3, 5=0, 2, 4, ...
    function automatic logic [2:0] rot_amt(input logic [4:0] r);
        logic [5:0] t;
        t = {r, 1'b0} - 6'd1;
        return 3'(t % 6'd5);
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t        state_q, state_nxt;
    logic [RW-1:0] rnd_q;
    logic [7:0]    chain_q;
    logic [7:0]    dout_q;

    logic [9:0]    key_q;
    logic          dec_q;
    logic [31:0]   s0_q, s1_q;
    logic [7:0]    din_q;
    logic [3:0]    l_q, r_q;

    // -----------------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------------
    logic          accept;
    logic          last;
    logic [7:0]    chain_eff;
    logic [7:0]    x_in;
    logic [7:0]    ip_x;
    logic [9:0]    k10;
    logic [4:0]    r_idx;
    logic [2:0]    sh;
    logic [7:0]    subkey;
    logic [7:0]    t_mix;
    logic [3:0]    f_out;
    logic [3:0]    l_new;
    logic [7:0]    y;

    assign accept = in_valid & in_ready;
    assign last   = (rnd_q == RW'(ROUNDS - 1));

    // chain_clr on the accepting edge makes this block chain from IV.
    assign chain_eff = chain_clr ? IV : chain_q;
    assign x_in      = (CBC_EN && !decrypt) ? (data_in ^ chain_eff) : data_in;
    assign ip_x      = ip(x_in);

    // Decrypt walks the key schedule backwards: ROUNDS..1.
    assign k10    = p10(key_q);
    assign r_idx  = dec_q ? (5'(ROUNDS) - 5'(rnd_q)) : (5'(rnd_q) + 5'd1);
    assign sh     = rot_amt(r_idx);
    assign subkey = p8({rol5(k10[9:5], sh), rol5(k10[4:0], sh)});

    assign t_mix  = ep(r_q) ^ subkey;
    assign f_out  = p4({sbox(s0_q, t_mix[7:4]), sbox(s1_q, t_mix[3:0])});
    assign l_new  = l_q ^ f_out;

    // The last round does not swap, so the output permutation sees (L',R).
    assign y      = ip_inv({l_new, r_q});

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (accept)    state_nxt = ROUND;
            ROUND:   if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    assign data_out = dout_q;

    // -----------------------------------------------------------------------
    // Control registers with reset: round counter, chain, result
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            rnd_q   <= '0;
            chain_q <= IV;
            dout_q  <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (chain_clr) chain_q <= IV;
                    if (accept)    rnd_q   <= '0;
                end
                ROUND: begin
                    if (last) begin
                        dout_q <= (CBC_EN && dec_q) ? (y ^ chain_q) : y;
                        // Chain always follows the ciphertext stream.
                        if (CBC_EN) chain_q <= dec_q ? din_q : y;
                    end else begin
                        rnd_q <= rnd_q + RW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Per-block datapath registers; contents are don't-care outside a block
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state_q == IDLE && accept) begin
            key_q <= key;
            dec_q <= decrypt;
            s0_q  <= S0;
            s1_q  <= S1;
            din_q <= data_in;
            l_q   <= ip_x[7:4];
            r_q   <= ip_x[3:0];
        end else if (state_q == ROUND) begin
            if (last) begin
                l_q <= l_new;
            end else begin
                l_q <= r_q;
                r_q <= l_new;
            end
        end
    end

endmodule
